id_fetch_queue: RTL

- Parametrised successor to the single IF→ID pipeline register, placed between IF and the ID decode logic.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry FIFO.
- Discards wrong-path entries on flush.
- Replaces the one-stage load-use check with a LOAD_LAT-deep load scoreboard. The head instruction is held until every pending load destination it reads has cleared.

---
 rtl/id_fetch_queue.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/id_fetch_queue.sv
// IF->ID fetch queue: a DEPTH-entry {pc, inst} FIFO with flush, plus a
// LOAD_LAT-deep load scoreboard that holds the head on load-use hazards.
module id_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [31:0]              fetch_pc,
    input  logic [31:0]              fetch_inst,
    output logic                     fetch_ready,
    input  logic                     flush,
    input  logic                     stall,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic                     stallreq,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          empty;
    logic          push;
    logic          fire;
    logic          hazard;

    logic [31:0]   head_pc;
    logic [31:0]   head_inst;
    logic [5:0]    opcode;
    logic [5:0]    func;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rs_used;
    logic          rt_used;
    logic          is_load;

    logic [LOAD_LAT-1:0] sb_v;
    logic [4:0]          sb_addr [LOAD_LAT];
    logic                rs_hit;
    logic                rt_hit;

    assign empty       = (count == '0);
    assign fetch_ready = (count != (AW+1)'(DEPTH));
    assign push        = fetch_valid & fetch_ready & ~flush;

    // Storage is not reset: unread slots are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= fetch_inst;
        end
    end

    // A flush drops the queue, but a head that fires this cycle still issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, fire};
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];
    assign opcode    = head_inst[31:26];
    assign rs        = head_inst[25:21];
    assign rt        = head_inst[20:16];
    assign func      = head_inst[5:0];

    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rt_used = (func != FN_JR);
                if (func == FN_SLL || func == FN_SRL || func == FN_SRA) begin
                    rs_used = 1'b0;
                end
            end
            OP_J, OP_JAL, OP_LUI: rs_used = 1'b0;
            OP_BEQ, OP_BNE, OP_SW: rt_used = 1'b1;
            OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU: is_load = 1'b1;
            default: ;
        endcase
    end

    // Issued loads are real even across a flush, so only reset clears the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                sb_addr[i] <= '0;
            end
        end else if (!stall) begin
            sb_v[0]    <= fire & is_load & (rt != 5'd0);
            sb_addr[0] <= rt;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_v[i]    <= sb_v[i-1];
                sb_addr[i] <= sb_addr[i-1];
            end
        end
    end

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_v[i] && sb_addr[i] == rs) begin
                rs_hit = 1'b1;
            end
            if (sb_v[i] && sb_addr[i] == rt) begin
                rt_hit = 1'b1;
            end
        end
    end

    assign hazard = ~empty & ((rs_used & (rs != 5'd0) & rs_hit) |
                              (rt_used & (rt != 5'd0) & rt_hit));

    assign id_valid = ~empty & ~hazard & ~stall;
    assign fire     = id_valid;
    assign stallreq = hazard;
    assign id_pc    = id_valid ? head_pc   : 32'd0;
    assign id_inst  = id_valid ? head_inst : 32'd0;

endmodule
